// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO with one-cycle registered read latency and re-presents
// the words on a valid/ready stream through a small credit-based skid buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  words_out
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      r_headPtr;
    logic [PTR_W-1:0]      r_tailPtr;
    logic [OCC_W-1:0]      r_occ;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_wordsOut;

    logic                  w_pop;
    logic                  w_push;
    logic [OCC_W:0]        w_credit;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop  = m_valid & m_ready;
    assign w_push = r_inflight;

    // Entries committed or already requested, less the one leaving this cycle.
    // A pop frees its slot immediately, which is what sustains one word per cycle.
    assign w_credit  = {1'b0, r_occ}
                     + {{OCC_W{1'b0}}, r_inflight}
                     - {{OCC_W{1'b0}}, w_pop};
    assign fifo_r_en = rst_n & ~flush & ~fifo_empty & (w_credit < {1'b0, DEPTH_OCC});

    assign m_valid   = (r_occ != '0);
    assign m_data    = r_mem[r_headPtr];
    assign words_out = r_wordsOut;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_headPtr  <= '0;
            r_tailPtr  <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_wordsOut <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_wordsOut <= r_wordsOut + CNT_WIDTH'(1);
            end

            // Flush drops the buffer and ignores whatever the FIFO returns this edge.
            if (flush) begin
                r_headPtr  <= '0;
                r_tailPtr  <= '0;
                r_occ      <= '0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= fifo_r_en;
                if (w_push) begin
                    r_mem[r_tailPtr] <= fifo_rdata;
                    r_tailPtr        <= nextPtr(r_tailPtr);
                end
                if (w_pop) begin
                    r_headPtr <= nextPtr(r_headPtr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + OCC_W'(1);
                    2'b01:   r_occ <= r_occ - OCC_W'(1);
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and a
// word-order scoreboard checks the stream, plus directed timing and flush cases.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BD = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifoEmpty = 1'b1;
    logic [DW-1:0] fifoRdata = '0;
    logic          fifoREn;
    logic          mValid;
    logic [DW-1:0] mData;
    logic          mReady;
    logic          flush;
    logic [CW-1:0] wordsOut;
    logic          fifoREn4;
    logic          mValid4;
    logic [DW-1:0] mData4;
    logic [3:0]    wordsOut4;

    logic          wrEn;
    logic [DW-1:0] wrData;
    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] expQ[$];

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifoEmpty), .fifo_rdata(fifoRdata),
        .fifo_r_en(fifoREn), .m_valid(mValid), .m_data(mData), .m_ready(mReady),
        .flush(flush), .words_out(wordsOut)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifoEmpty), .fifo_rdata(fifoRdata),
        .fifo_r_en(fifoREn4), .m_valid(mValid4), .m_data(mData4), .m_ready(mReady),
        .flush(flush), .words_out(wordsOut4)
    );

    // Synchronous FIFO model: registered read data, empty flag follows the count.
    always @(posedge clk) begin
        if (!rst_n) begin
            fifoQ.delete();
            fifoRdata <= '0;
        end else begin
            if (fifoREn && fifoQ.size() > 0) begin
                fifoRdata <= fifoQ.pop_front();
            end
            if (wrEn) begin
                fifoQ.push_back(wrData);
            end
        end
        fifoEmpty <= (fifoQ.size() == 0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [DW-1:0] d);
        wrEn   = w;
        wrData = d;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic endCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] t1Words[3];
        logic [DW-1:0] w2[8];
        logic [DW-1:0] fw[6];
        logic [DW-1:0] ww[17];
        int reads, stallBad, got, gaps, written, delivered, issued;
        logic prevStall;
        logic [DW-1:0] prevData;
        logic [31:0] expWord;

        t1Words[0] = 8'h11;
        t1Words[1] = 8'h22;
        t1Words[2] = 8'h33;

        rst_n  = 1'b0;
        mReady = 1'b0;
        flush  = 1'b0;
        applyStimulus(1'b0, '0);
        repeat (3) endCycle();
        midCycle();
        checkOutput("resetREn", fifoREn, 0);
        checkOutput("resetValid", mValid, 0);
        checkOutput("resetData", mData, 0);
        checkOutput("resetWords", wordsOut, 0);
        endCycle();

        $display("[TB] basic latency and throughput");
        rst_n  = 1'b1;
        flush  = 1'b1;
        mReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, t1Words[i]);
            endCycle();
        end
        applyStimulus(1'b0, '0);
        flush = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            midCycle();
            checkOutput($sformatf("t1REn_c%0d", c), fifoREn, (c >= 1 && c <= 3));
            checkOutput($sformatf("t1Valid_c%0d", c), mValid, (c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) begin
                checkOutput($sformatf("t1Data_c%0d", c), mData, t1Words[c-3]);
            end
            checkOutput($sformatf("t1Words_c%0d", c), wordsOut, (c <= 3) ? 0 : ((c >= 6) ? 3 : c - 3));
            endCycle();
        end

        $display("[TB] back-pressure then release");
        flush  = 1'b1;
        mReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w2[i] = DW'($urandom);
            applyStimulus(1'b1, w2[i]);
            endCycle();
        end
        applyStimulus(1'b0, '0);
        flush    = 1'b0;
        reads    = 0;
        stallBad = 0;
        for (int c = 0; c < 10; c++) begin
            midCycle();
            if (fifoREn) reads++;
            if (mValid && mData !== w2[0]) stallBad++;
            endCycle();
        end
        midCycle();
        checkOutput("t2Reads", reads, BD);
        checkOutput("t2StallStable", stallBad, 0);
        checkOutput("t2Valid", mValid, 1);
        checkOutput("t2Data", mData, w2[0]);
        checkOutput("t2REnHeld", fifoREn, 0);
        endCycle();
        mReady = 1'b1;
        got  = 0;
        gaps = 0;
        for (int c = 0; c < 20 && got < 8; c++) begin
            midCycle();
            if (mValid) begin
                checkOutput($sformatf("t2Word%0d", got), mData, w2[got]);
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            endCycle();
        end
        checkOutput("t2Delivered", got, 8);
        checkOutput("t2Gaps", gaps, 0);
        midCycle();
        checkOutput("t2WordsOut", wordsOut, 11);
        endCycle();

        $display("[TB] flush with a read in flight");
        flush  = 1'b1;
        mReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fw[i] = DW'($urandom);
            applyStimulus(1'b1, fw[i]);
            endCycle();
        end
        applyStimulus(1'b0, '0);
        flush = 1'b0;
        repeat (4) endCycle();
        midCycle();
        checkOutput("t3Full", mValid, 1);
        checkOutput("t3FullREn", fifoREn, 0);
        endCycle();
        mReady = 1'b1;
        midCycle();
        checkOutput("t3IssueREn", fifoREn, 1);
        checkOutput("t3PopData", mData, fw[0]);
        endCycle();
        flush = 1'b1;
        midCycle();
        checkOutput("t3FlushREn", fifoREn, 0);
        checkOutput("t3FlushPopData", mData, fw[1]);
        endCycle();
        flush  = 1'b0;
        mReady = 1'b0;
        midCycle();
        checkOutput("t3AfterFlushValid", mValid, 0);
        endCycle();
        mReady = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            midCycle();
            if (mValid && mReady) begin
                checkOutput($sformatf("t3Word%0d", got), mData, fw[3+got]);
                got++;
            end
            endCycle();
        end
        checkOutput("t3Delivered", got, 3);
        midCycle();
        checkOutput("t3WordsOut", wordsOut, 16);
        endCycle();

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, DW'($urandom));
            endCycle();
        end
        applyStimulus(1'b0, '0);
        midCycle();
        checkOutput("t4Streaming", mValid, 1);
        rst_n = 1'b0;
        endCycle();
        midCycle();
        checkOutput("t4REn", fifoREn, 0);
        checkOutput("t4Valid", mValid, 0);
        checkOutput("t4Data", mData, 0);
        checkOutput("t4Words", wordsOut, 0);
        checkOutput("t4REn4", fifoREn4, 0);
        checkOutput("t4Valid4", mValid4, 0);
        checkOutput("t4Data4", mData4, 0);
        checkOutput("t4Words4", wordsOut4, 0);
        endCycle();
        rst_n = 1'b1;

        $display("[TB] counter wrap on narrow instance");
        for (int i = 0; i < 17; i++) ww[i] = DW'(i * 7 + 3);
        got = 0;
        for (int c = 0; c < 60 && got < 17; c++) begin
            if (c < 17) applyStimulus(1'b1, ww[c]);
            else        applyStimulus(1'b0, '0);
            midCycle();
            if (mValid && mReady) begin
                checkOutput($sformatf("t5Word%0d", got), mData, ww[got]);
                checkOutput($sformatf("t5Word4_%0d", got), mData4, ww[got]);
                got++;
            end
            endCycle();
        end
        applyStimulus(1'b0, '0);
        midCycle();
        checkOutput("t5WordsOut", wordsOut, 17);
        checkOutput("t5WordsOut4", wordsOut4, 1);
        endCycle();

        $display("[TB] random traffic scoreboard");
        rst_n = 1'b0;
        repeat (2) endCycle();
        rst_n     = 1'b1;
        written   = 0;
        delivered = 0;
        issued    = 0;
        prevStall = 1'b0;
        prevData  = '0;
        expQ.delete();
        for (int c = 0; c < 6000 && delivered < 200; c++) begin
            if (written < 200 && $urandom_range(0, 1) == 1) begin
                applyStimulus(1'b1, DW'($urandom));
                expQ.push_back(wrData);
                written++;
            end else begin
                applyStimulus(1'b0, '0);
            end
            mReady = ($urandom_range(0, 1) == 1);
            midCycle();
            checkOutput("t6REnWhileEmpty", fifoREn & fifoEmpty, 0);
            checkOutput("t6Outstanding", (issued - delivered) <= BD, 1);
            if (prevStall) begin
                checkOutput("t6HoldValid", mValid, 1);
                checkOutput("t6HoldData", mData, prevData);
            end
            if (fifoREn) issued++;
            if (mValid && mReady) begin
                expWord = (expQ.size() > 0) ? 32'(expQ.pop_front()) : 32'hDEAD_BEEF;
                checkOutput($sformatf("t6Word%0d", delivered), mData, expWord);
                delivered++;
            end
            prevStall = mValid & ~mReady;
            prevData  = mData;
            endCycle();
        end
        applyStimulus(1'b0, '0);
        checkOutput("t6Delivered", delivered, 200);
        checkOutput("t6Leftover", expQ.size(), 0);
        midCycle();
        checkOutput("t6WordsOut", wordsOut, 200);
        endCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side companion for the team's synchronous FIFO. Drains the FIFO through its `r_en`/`empty`/`data_out` port and accounts for the FIFO's one-cycle registered read latency. Re-presents the words on a valid/ready stream with a small internal skid buffer, so downstream back-pressure never loses or duplicates a word. Sits between any synchronous FIFO instance and a streaming consumer; includes a synchronous flush and a delivered-word counter.

## Interface
- `DATA_WIDTH`, 8, width of FIFO data and stream data
- `BUF_DEPTH`, 2, skid-buffer entries; legal range 2..8
- `CNT_WIDTH`, 16, width of delivered-word counter
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `fifo_empty`  in  1  FIFO empty flag (combinational from FIFO count)
- `fifo_rdata`  in  DATA_WIDTH  FIFO `data_out`; registered on the edge ending a cycle with `r_en & !empty`
- `fifo_r_en`  out  1  read request to FIFO
- `m_valid`  out  1  stream word valid
- `m_data`  out  DATA_WIDTH  stream word
- `m_ready`  in  1  downstream accepts word
- `flush`  in  1  synchronous flush: discard buffered and in-flight words
- `words_out`  out  CNT_WIDTH  count of stream handshakes (`m_valid & m_ready`)

## Operation
- State: circular buffer of BUF_DEPTH entries with head/tail pointers, occupancy `occ` (0..BUF_DEPTH), 1-bit `inflight`, and counter.
- `pop = m_valid & m_ready`.
- `fifo_r_en = rst_n & !flush & !fifo_empty & ((occ + inflight - pop) < BUF_DEPTH)`. Combinational; it is never asserted while `fifo_empty=1`.
- `inflight` is set to the value of `fifo_r_en` at the next edge. While `inflight=1`, `fifo_rdata` is written to the tail at the end of that cycle.
- `m_valid = (occ != 0)`; `m_data` = head entry. Push and pop in the same cycle: `occ` unchanged, both pointers advance.
- Pointers wrap modulo BUF_DEPTH. Occupancy arithmetic uses `$clog2(BUF_DEPTH)+1` bits, so no overflow at `occ=BUF_DEPTH`.
- Word order is strictly preserved: FIFO read order equals stream order.
- `flush=1` at an edge:
  - clears `occ`, both pointers, and `inflight`;
  - the word returned for a read issued in the flush cycle's predecessor is discarded;
  - `fifo_r_en=0` during the flush cycle;
  - `words_out` is not cleared.
- A handshake in the flush cycle still counts in `words_out`; flush has priority for buffer state.
- `words_out` increments on every `pop` and wraps at 2^CNT_WIDTH.
- Reset values: `occ=0`, `inflight=0`, pointers 0, `m_valid=0`, `m_data=0` (buffer cleared), `words_out=0`, `fifo_r_en=0`. Reset mid-transfer drops all buffered and in-flight words. The FIFO is reset by the same `rst_n`.

## Timing
- Latency: `fifo_r_en` in cycle N → `fifo_rdata` valid in N+1 → `m_valid` high in N+2 (empty buffer case).
- Throughput: one word per cycle sustained while FIFO non-empty and `m_ready=1` (BUF_DEPTH≥2 suffices because `pop` frees a credit in the same cycle).
- `m_valid`/`m_data` held stable while `m_valid & !m_ready`. `m_valid` never drops without a handshake except on flush/reset.
- With `m_ready=0`: at most BUF_DEPTH reads are issued, then `fifo_r_en` stays low until a pop.

## Test plan
- Reset then FIFO preloaded with 0x11,0x22,0x33, `m_ready=1` → `fifo_r_en` high cycles 1–3; `m_data` 0x11,0x22,0x33 in cycles 3–5; `words_out=3`; `fifo_r_en` low once FIFO empty.
- FIFO holds 8 words, `m_ready=0` for 10 cycles → exactly 2 reads issued, `m_valid=1`, `m_data` stable at first word; release `m_ready` → all 8 delivered in order, no gaps after the first.
- Random `m_ready` (50%) over 200 words with random FIFO writes → scoreboard: stream equals written order, no loss/duplication, `words_out=200`.
- `flush` asserted the cycle after a read issue with 2 words buffered → `m_valid=0` next cycle, in-flight word discarded; the next streamed word is the following FIFO entry.
- `rst_n=0` mid-stream → all outputs at reset values next cycle; `words_out=0`.
- `CNT_WIDTH=4`, 17 handshakes → `words_out` wraps to 1.
